// File: rtl/opnd_fetch_sb_pkg.sv
// opnd_fetch_sb_pkg: shared widths and constants for the operand-fetch stage.
package opnd_fetch_sb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [31:0] ZeroWord = 32'h0;
    localparam logic [4:0] NOPRegAddr = 5'h0;
    localparam logic RstEnable = 1'b0;
endpackage

// File: rtl/opnd_fetch_sb_opnd_sel.sv
// opnd_fetch_sb_opnd_sel: per-port operand select and hazard detection.
module opnd_fetch_sb_opnd_sel
    import opnd_fetch_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_FWD = 2
) (
    input  logic                      i_rd_en,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_imm,
    input  logic [NUM_FWD-1:0]        i_fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_addr,
    input  logic [NUM_FWD-1:0]        i_fwd_rdy,
    input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
    input  logic                      i_busy,
    input  logic                      i_wb_we,
    input  logic [ADDR_W-1:0]         i_wb_addr,
    input  logic [DATA_W-1:0]         i_wb_data,
    input  logic [DATA_W-1:0]         i_arr,
    output logic [DATA_W-1:0]         o_opnd,
    output logic                      o_haz
);
    logic              w_hit;
    logic              w_rdy;
    logic [DATA_W-1:0] w_fdata;
    logic              w_zero;
    // descending scan so the lowest-index matching source wins
    always_comb begin
        w_hit = 1'b0;
        w_rdy = 1'b0;
        w_fdata = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_fwd_we[k] && i_fwd_addr[k*ADDR_W +: ADDR_W] == i_addr) begin
                w_hit = 1'b1;
                w_rdy = i_fwd_rdy[k];
                w_fdata = i_fwd_data[k*DATA_W +: DATA_W];
            end
        end
    end
    assign w_zero = i_addr == ADDR_W'(NOPRegAddr);
    assign o_opnd = !i_rd_en ? i_imm :
                    w_zero ? DATA_W'(ZeroWord) :
                    w_hit ? w_fdata :
                    (i_wb_we && i_wb_addr == i_addr) ? i_wb_data : i_arr;
    assign o_haz = i_rd_en && !w_zero && (w_hit ? !w_rdy : i_busy);
endmodule

// File: rtl/opnd_fetch_sb.sv
// opnd_fetch_sb: register file, busy scoreboard and ID/EX operand register.
module opnd_fetch_sb
    import opnd_fetch_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      Rst_n,
    input  logic                      in_valid_i,
    input  logic [NUM_RD-1:0]         rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr_i,
    input  logic [NUM_RD*DATA_W-1:0]  imm_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr_i,
    input  logic [NUM_FWD-1:0]        fwd_rdy_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
    input  logic                      wb_we_i,
    input  logic [ADDR_W-1:0]         wb_addr_i,
    input  logic [DATA_W-1:0]         wb_data_i,
    input  logic                      sb_set_i,
    input  logic [ADDR_W-1:0]         sb_set_addr_i,
    input  logic                      sb_clr_i,
    input  logic [ADDR_W-1:0]         sb_clr_addr_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      stall_req_o,
    output logic [NUM_RD*DATA_W-1:0]  opnd_o,
    output logic                      out_valid_o,
    output logic                      sb_err_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0]        r_arr [DEPTH];
    logic [DEPTH-1:0]         r_busy;
    logic [NUM_RD*DATA_W-1:0] r_opnd;
    logic                     r_valid;
    logic                     r_err;
    logic [NUM_RD*DATA_W-1:0] w_opnd;
    logic [NUM_RD-1:0]        w_haz;
    logic [NUM_RD-1:0]        w_busy;
    logic                     w_stall;
    logic                     w_set_ok;
    logic                     w_clr_ok;
    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_port
            // a clear in this cycle releases the register for this cycle's read
            assign w_busy[g] = r_busy[rd_addr_i[g*ADDR_W +: ADDR_W]] &&
                               !(sb_clr_i && sb_clr_addr_i == rd_addr_i[g*ADDR_W +: ADDR_W]);
            opnd_fetch_sb_opnd_sel #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NUM_FWD(NUM_FWD)
            ) u_sel (
                .i_rd_en   (rd_en_i[g]),
                .i_addr    (rd_addr_i[g*ADDR_W +: ADDR_W]),
                .i_imm     (imm_i[g*DATA_W +: DATA_W]),
                .i_fwd_we  (fwd_we_i),
                .i_fwd_addr(fwd_addr_i),
                .i_fwd_rdy (fwd_rdy_i),
                .i_fwd_data(fwd_data_i),
                .i_busy    (w_busy[g]),
                .i_wb_we   (wb_we_i),
                .i_wb_addr (wb_addr_i),
                .i_wb_data (wb_data_i),
                .i_arr     (r_arr[rd_addr_i[g*ADDR_W +: ADDR_W]]),
                .o_opnd    (w_opnd[g*DATA_W +: DATA_W]),
                .o_haz     (w_haz[g])
            );
        end
    endgenerate
    assign w_stall = in_valid_i && |w_haz;
    assign w_set_ok = sb_set_i && sb_set_addr_i != ADDR_W'(NOPRegAddr);
    assign w_clr_ok = sb_clr_i && sb_clr_addr_i != ADDR_W'(NOPRegAddr);
    always_ff @(posedge clk) begin
        if (Rst_n == RstEnable) begin
            r_arr <= '{default: '0};
            r_busy <= '0;
            r_opnd <= '0;
            r_valid <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (wb_we_i && wb_addr_i != ADDR_W'(NOPRegAddr)) r_arr[wb_addr_i] <= wb_data_i;
            if (w_clr_ok) r_busy[sb_clr_addr_i] <= 1'b0;
            if (w_set_ok) r_busy[sb_set_addr_i] <= 1'b1;
            r_err <= w_set_ok && r_busy[sb_set_addr_i] && !(sb_clr_i && sb_clr_addr_i == sb_set_addr_i);
            if (flush_i) r_valid <= 1'b0;
            else if (!stall_i) begin
                r_valid <= in_valid_i && !w_stall;
                r_opnd <= w_opnd;
            end
        end
    end
    assign stall_req_o = (Rst_n != RstEnable) && w_stall;
    assign opnd_o = r_opnd;
    assign out_valid_o = r_valid;
    assign sb_err_o = r_err;
endmodule

// File: tb/tb_opnd_fetch_sb.sv
// tb_opnd_fetch_sb: directed and random checks of opnd_fetch_sb against a behavioural model.
module tb_opnd_fetch_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] imm;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_addr;
    logic [1:0]  fwd_rdy;
    logic [63:0] fwd_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        sb_set;
    logic [4:0]  sb_set_addr;
    logic        sb_clr;
    logic [4:0]  sb_clr_addr;
    logic        stall;
    logic        flush;
    logic        stall_req_o;
    logic [63:0] opnd_o;
    logic        out_valid_o;
    logic        sb_err_o;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_arr [32];
    bit          m_busy [32];
    logic [31:0] m_opnd [2];
    bit          m_known [2];
    bit          m_valid;
    bit          m_err;

    opnd_fetch_sb dut (
        .clk          (clk),
        .Rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .imm_i        (imm),
        .fwd_we_i     (fwd_we),
        .fwd_addr_i   (fwd_addr),
        .fwd_rdy_i    (fwd_rdy),
        .fwd_data_i   (fwd_data),
        .wb_we_i      (wb_we),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .sb_set_i     (sb_set),
        .sb_set_addr_i(sb_set_addr),
        .sb_clr_i     (sb_clr),
        .sb_clr_addr_i(sb_clr_addr),
        .stall_i      (stall),
        .flush_i      (flush),
        .stall_req_o  (stall_req_o),
        .opnd_o       (opnd_o),
        .out_valid_o  (out_valid_o),
        .sb_err_o     (sb_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Operand the specification asks for, plus whether the port must wait.
    function automatic logic [31:0] m_sel(input int p, output bit haz);
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        haz = 1'b0;
        if (!rd_en[p]) return imm[p*32 +: 32];
        if (a == 0) return 32'h0;
        for (int k = 0; k < 2; k++)
            if (fwd_we[k] && fwd_addr[k*5 +: 5] == a) begin
                haz = !fwd_rdy[k];
                return fwd_data[k*32 +: 32];
            end
        if (m_busy[a] && !(sb_clr && sb_clr_addr == a)) begin
            haz = 1'b1;
            return 32'h0;
        end
        if (wb_we && wb_addr == a) return wb_data;
        return m_arr[a];
    endfunction

    task automatic idle();
        rst_n = 1'b1; in_valid = 0; rd_en = 0; rd_addr = 0; imm = 0;
        fwd_we = 0; fwd_addr = 0; fwd_rdy = 0; fwd_data = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        sb_set = 0; sb_set_addr = 0; sb_clr = 0; sb_clr_addr = 0;
        stall = 0; flush = 0;
    endtask

    // One clock: check the combinational stall, advance the model, check registers.
    task automatic tick();
        bit h0, h1, es;
        logic [31:0] s0, s1;
        #1;
        s0 = m_sel(0, h0);
        s1 = m_sel(1, h1);
        es = rst_n && in_valid && (h0 || h1);
        chk("stall_req", {31'b0, stall_req_o}, {31'b0, es});
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin m_arr[i] = 0; m_busy[i] = 0; end
            m_opnd[0] = 0; m_opnd[1] = 0; m_known[0] = 1; m_known[1] = 1;
            m_valid = 0; m_err = 0;
        end else begin
            m_err = sb_set && sb_set_addr != 0 && m_busy[sb_set_addr] &&
                    !(sb_clr && sb_clr_addr == sb_set_addr);
            if (sb_clr && sb_clr_addr != 0) m_busy[sb_clr_addr] = 0;
            if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1;
            if (wb_we && wb_addr != 0) m_arr[wb_addr] = wb_data;
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_valid = in_valid && !es;
                m_opnd[0] = s0; m_known[0] = !h0;
                m_opnd[1] = s1; m_known[1] = !h1;
            end
        end
        #1;
        chk("out_valid", {31'b0, out_valid_o}, {31'b0, m_valid});
        chk("sb_err", {31'b0, sb_err_o}, {31'b0, m_err});
        if (m_known[0]) chk("opnd0", opnd_o[31:0], m_opnd[0]);
        if (m_known[1]) chk("opnd1", opnd_o[63:32], m_opnd[1]);
    endtask

    initial begin
        idle();
        for (int i = 0; i < 32; i++) begin m_arr[i] = 0; m_busy[i] = 0; end
        m_known[0] = 0; m_known[1] = 0; m_valid = 0; m_err = 0;
        // reset while a writeback to r5 is requested
        rst_n = 0; wb_we = 1; wb_addr = 5; wb_data = 32'hCAFEF00D; in_valid = 1; rd_en = 2'b01;
        rd_addr = 10'd5; sb_set = 1; sb_set_addr = 5; fwd_we = 2'b01; fwd_addr = 10'd5;
        tick(); tick();
        chk("rst_opnd", opnd_o[31:0], 32'h0);
        chk("rst_valid", {31'b0, out_valid_o}, 32'h0);
        idle(); in_valid = 1; rd_en = 2'b01; rd_addr = 10'd5;
        tick();
        chk("rst_r5", opnd_o[31:0], 32'h0);
        // forwarding priority over a lower source and writeback
        idle(); in_valid = 1; rd_en = 2'b01; rd_addr = 10'd3;
        fwd_we = 2'b11; fwd_rdy = 2'b11; fwd_addr = {5'd3, 5'd3};
        fwd_data = {32'h12345678, 32'hAAAA0000}; wb_we = 1; wb_addr = 3; wb_data = 32'h1;
        tick();
        chk("prio", opnd_o[31:0], 32'hAAAA0000);
        // load-use: EX not ready, then MEM delivers
        idle(); in_valid = 1; rd_en = 2'b10; rd_addr = {5'd4, 5'd0}; fwd_we = 2'b01; fwd_addr = {5'd0, 5'd4};
        tick();
        chk("lu_bubble", {31'b0, out_valid_o}, 32'h0);
        fwd_we = 2'b10; fwd_rdy = 2'b10; fwd_addr = {5'd4, 5'd0}; fwd_data = {32'h0000DEAD, 32'h0};
        tick();
        chk("lu_data", opnd_o[63:32], 32'h0000DEAD);
        chk("lu_valid", {31'b0, out_valid_o}, 32'h1);
        // scoreboard busy, clear with same-cycle writeback, double set
        idle(); sb_set = 1; sb_set_addr = 7;
        tick();
        idle(); in_valid = 1; rd_en = 2'b01; rd_addr = 10'd7;
        tick(); tick(); tick();
        sb_clr = 1; sb_clr_addr = 7; wb_we = 1; wb_addr = 7; wb_data = 32'h55;
        tick();
        chk("sb_release", opnd_o[31:0], 32'h55);
        idle(); sb_set = 1; sb_set_addr = 7;
        tick(); tick();
        chk("sb_err", {31'b0, sb_err_o}, 32'h1);
        idle(); sb_clr = 1; sb_clr_addr = 7;
        tick();
        chk("sb_err_pulse", {31'b0, sb_err_o}, 32'h0);
        // zero register and immediate
        idle(); wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
        tick();
        idle(); in_valid = 1; rd_en = 2'b01; rd_addr = 10'd0; fwd_we = 2'b01; fwd_addr = 10'd0;
        fwd_data = 32'hBEEF; imm = {32'h00001234, 32'h0};
        tick();
        chk("r0", opnd_o[31:0], 32'h0);
        chk("imm", opnd_o[63:32], 32'h00001234);
        // stall holds, flush beats stall
        idle(); in_valid = 1; imm = {32'h11111111, 32'h22222222};
        tick();
        stall = 1; imm = {32'h33333333, 32'h44444444}; in_valid = 0;
        tick();
        chk("stall_hold", opnd_o[31:0], 32'h22222222);
        chk("stall_valid", {31'b0, out_valid_o}, 32'h1);
        flush = 1;
        tick();
        chk("flush", {31'b0, out_valid_o}, 32'h0);
        // random traffic over a small register window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            in_valid = $urandom_range(0, 3) != 0;
            rd_en = 2'($urandom);
            rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            imm = {$urandom, $urandom};
            fwd_we = 2'($urandom);
            fwd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_rdy = 2'($urandom);
            fwd_data = {$urandom, $urandom};
            wb_we = $urandom_range(0, 1);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            sb_set = $urandom_range(0, 4) == 0;
            sb_set_addr = 5'($urandom_range(0, 7));
            sb_clr = $urandom_range(0, 2) == 0;
            sb_clr_addr = 5'($urandom_range(0, 7));
            stall = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 9) == 0;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
